// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               sq_q, sq_d;
    logic               sr_q, sr_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;
    logic               remGe;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    // Operands are reduced to magnitudes at start; signs are re-applied in FIX.
    assign aNeg     = ~op[0] & a[WIDTH-1];
    assign bNeg     = ~op[0] & b[WIDTH-1];
    assign aMag     = aNeg ? -a : a;
    assign bMag     = bNeg ? -b : b;
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign remShift = {rem_q, acc_q[WIDTH-1]};
    assign remGe    = remShift >= {1'b0, b_q};
    assign prodFix  = sq_q ? -acc_q : acc_q;
    assign quoFix   = sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remFix   = sr_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        b_d     = b_q;
        araw_d  = araw_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = op[1];
                    sq_d    = aNeg ^ bNeg;
                    sr_d    = aNeg;
                    b_d     = bMag;
                    araw_d  = a;
                    rem_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, aMag};
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    // The quotient bit shifts into the low half as the dividend shifts out.
                    rem_d = remGe ? (remShift[WIDTH-1:0] - b_q) : remShift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], remGe};
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = remFix;
                    lo_d = quoFix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            b_q     <= '0;
            araw_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            b_q     <= b_d;
            araw_q  <= araw_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: 32-bit instance for arithmetic, handshake, enable and reset,
// plus an 8-bit instance for the narrow-width vectors.
module tb_mips_muldiv;

    logic        clk;
    logic        reset;
    logic        clkEnable;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;
    logic        one8;
    logic        zero8;
    logic [7:0]  wdata8;

    int checkCount = 0;
    int passCount  = 0;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clkEnable), .start(start), .op(op),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .clk_enable(one8), .start(start8), .op(op8),
        .a(a8), .b(b8), .mthi(zero8), .mtlo(zero8), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Starts one operation on the 32-bit unit and follows it to done, optionally gating the
    // clock enable, poking start/mthi mid-run, or pairing mtlo with start.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input int expEdges, input int disAt,
                                 input int pokeAt, input bit withMtlo);
        logic [31:0] oldHi, oldLo;
        int edges, busyCnt;
        oldHi = hi;
        oldLo = lo;
        op = o; a = x; b = y; start = 1'b1;
        if (withMtlo) begin
            mtlo  = 1'b1;
            wdata = 32'h5555;
        end
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        edges = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && edges < 100) begin
            if (edges == disAt) clkEnable = 1'b0;
            if (edges == disAt + 5) clkEnable = 1'b1;
            if (edges == pokeAt) begin
                start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
                op = 2'b11; a = 32'h99; b = 32'h3;
            end
            @(posedge clk); #1;
            edges++;
            start = 1'b0; mthi = 1'b0;
            if (busy) busyCnt++;
            if (edges == 30) begin
                checkOutput({tag, " hiHold"}, hi, oldHi);
                checkOutput({tag, " loHold"}, lo, oldLo);
            end
        end
        checkOutput({tag, " doneEdge"}, edges, expEdges);
        checkOutput({tag, " busyCycles"}, busyCnt, expEdges);
        checkOutput({tag, " hi"}, hi, expHi);
        checkOutput({tag, " lo"}, lo, expLo);
    endtask

    task automatic applyStimulus8(input string tag, input logic [1:0] o, input logic [7:0] x,
                                  input logic [7:0] y, input logic [7:0] expHi, input logic [7:0] expLo);
        int edges;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        while (!done8 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, " doneEdge"}, edges, 9);
        checkOutput({tag, " hi"}, hi8, expHi);
        checkOutput({tag, " lo"}, lo8, expLo);
    endtask

    initial begin
        reset = 1'b1; clkEnable = 1'b1; start = 1'b0; op = 2'b00;
        a = '0; b = '0; wdata = '0; mthi = 1'b0; mtlo = 1'b0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; one8 = 1'b1; zero8 = 1'b0; wdata8 = '0;
        #1;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetHi", hi, 0);
        checkOutput("resetLo", lo, 0);
        checkOutput("resetBusy8", busy8, 0);
        #19;
        reset = 1'b0;

        applyStimulus("multuMax", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, -1, -1, 1'b0);
        clkEnable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("doneHeldDisabled", done, 1);
        clkEnable = 1'b1;
        @(posedge clk); #1;
        checkOutput("doneFalls", done, 0);

        applyStimulus("multNeg", 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, -1, -1, 1'b0);
        applyStimulus("multMin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, -1, -1, 1'b0);
        applyStimulus("divNeg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, -1, -1, 1'b0);
        applyStimulus("divuZero", 2'b11, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 33, -1, -1, 1'b0);
        applyStimulus("divZeroNeg", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, -1, -1, 1'b0);
        applyStimulus("divMinNeg1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, -1, -1, 1'b0);

        mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        checkOutput("mthiHi", hi, 32'h1234);
        checkOutput("mthiLoKept", lo, 32'h80000000);
        checkOutput("mthiNoDone", done, 0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        checkOutput("mtBothHi", hi, 32'h77);
        checkOutput("mtBothLo", lo, 32'h77);

        applyStimulus("pokeIgnored", 2'b01, 32'h6, 32'h7, 32'h0, 32'h2A, 33, -1, 5, 1'b0);
        @(posedge clk); #1;
        checkOutput("pokeNoRequeue", busy, 0);
        checkOutput("pokeSingleDone", done, 0);

        applyStimulus("startMtlo", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 33, -1, -1, 1'b1);
        applyStimulus("divEnableGap", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 38, 10, -1, 1'b0);

        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortHi", hi, 0);
        checkOutput("abortLo", lo, 0);
        #2;
        reset = 1'b0;
        applyStimulus("multuAfterReset", 2'b01, 32'h3, 32'h5, 32'h0, 32'hF, 33, -1, -1, 1'b0);

        applyStimulus8("w8DivNeg", 2'b10, 8'hF9, 8'h02, 8'hFF, 8'hFD);
        applyStimulus8("w8MultNeg", 2'b00, 8'hFD, 8'h07, 8'hFF, 8'hEB);
        applyStimulus8("w8MultuMax", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        applyStimulus8("w8DivuZero", 2'b11, 8'h07, 8'h00, 8'h07, 8'hFF);
        applyStimulus8("w8DivMin", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
